rsa_mont_precompute: RTL and testbench

//  Upstream set-up stage for the Montgomery modular exponentiator. Given an odd

---
 rtl/rsa_mont_precompute.sv | 113 +++++++++++
 tb/tb_rsa_mont_precompute.sv | 135 +++++++++++++
 2 files changed

// File: rtl/rsa_mont_precompute.sv
// Montgomery set-up stage: derives mp = -m^-1 mod 2^WORD, r_mod = 2^WIDTH mod m
// and r2_mod = 2^(2*WIDTH) mod m by repeated modular doubling over 2*WIDTH cycles.
module rsa_mont_precompute #(
  parameter int WIDTH = 256,
  parameter int WORD  = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] modulos,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WORD-1:0]  mp,
  output logic [WIDTH-1:0] r_mod,
  output logic [WIDTH-1:0] r2_mod
);

  localparam int CW = $clog2(2 * WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, ERR, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] m;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] rm_work;
  logic [WORD-1:0]  x;
  logic [WORD-1:0]  p;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   t;
  logic [WIDTH:0]   r_next;
  logic [WORD-1:0]  sel;
  logic [WORD-1:0]  m0_shift;
  logic             take;

  always_comb begin
    t        = {r[WIDTH-1:0], 1'b0};
    r_next   = (t >= {1'b0, m}) ? t - {1'b0, m} : t;
    // Bit i = cnt+1 of the running product decides whether x gains 2^i.
    sel      = {{(WORD-1){1'b0}}, 1'b1} << (cnt + CW'(1));
    m0_shift = m[WORD-1:0] << (cnt + CW'(1));
    take     = (cnt < CW'(WORD - 1)) && (|(p & sel));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      mp      <= '0;
      r_mod   <= '0;
      r2_mod  <= '0;
      m       <= '0;
      r       <= '0;
      rm_work <= '0;
      x       <= '0;
      p       <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m       <= modulos;
            busy    <= 1'b1;
            cnt     <= '0;
            x       <= WORD'(1);
            p       <= modulos[WORD-1:0];
            rm_work <= '0;
            // For m=1 the Montgomery "1" is already 0; doubling 1 would never reduce.
            r       <= (modulos == WIDTH'(1)) ? '0 : (WIDTH+1)'(1);
            state   <= modulos[0] ? RUN : ERR;
          end
        end
        RUN: begin
          r <= r_next;
          if (take) begin
            x <= x + sel;
            p <= p + m0_shift;
          end
          if (cnt == CW'(WIDTH - 1))
            rm_work <= r_next[WIDTH-1:0];
          if (cnt == CW'(2 * WIDTH - 1))
            state <= DONE;
          else
            cnt <= cnt + CW'(1);
        end
        ERR: begin
          done   <= 1'b1;
          err    <= 1'b1;
          mp     <= '0;
          r_mod  <= '0;
          r2_mod <= '0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        DONE: begin
          mp     <= ~x + WORD'(1);
          r_mod  <= rm_work;
          r2_mod <= r[WIDTH-1:0];
          done   <= 1'b1;
          err    <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_mont_precompute.sv
// Directed and small randomised checks of rsa_mont_precompute (WIDTH=256, WORD=32).
module tb_rsa_mont_precompute;
  localparam int W = 256;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] modulos = '0;
  logic         busy, done, err;
  logic [31:0]  mp;
  logic [W-1:0] r_mod, r2_mod;

  int total = 0;
  int bad = 0;

  rsa_mont_precompute #(.WIDTH(W), .WORD(32)) dut (
    .clk(clk), .rstn(rstn), .start(start), .modulos(modulos),
    .busy(busy), .done(done), .err(err),
    .mp(mp), .r_mod(r_mod), .r2_mod(r2_mod)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Accepts m at edge T, then watches ncyc further edges; inputs change #1 after edges.
  task automatic run(input logic [W-1:0] m, input bit disturb, input int ncyc,
                     output int done_at, output int ndone, output int busy_cnt);
    done_at = -1; ndone = 0; busy_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; modulos = m;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy) busy_cnt++;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = k;
      end
      if (busy) busy_cnt++;
      if (disturb && (k == 9 || k == 299)) start = 1'b1;
      if (disturb && k == 50) modulos = {W{1'b1}};
    end
  endtask

  function automatic logic [W-1:0] pow2_mod(input logic [W-1:0] m, input int e);
    logic [512:0] one;
    logic [512:0] v;
    one = 513'd1;
    v = (one << e) % {257'd0, m};
    return v[W-1:0];
  endfunction

  // Newton iteration for the inverse, then negate.
  function automatic logic [31:0] ref_mp(input logic [31:0] m0);
    logic [31:0] xi;
    xi = m0;
    for (int i = 0; i < 5; i++) xi = xi * (32'd2 - m0 * xi);
    return -xi;
  endfunction

  task automatic full_check(input string tag, input logic [W-1:0] m, input logic [31:0] emp,
                            input logic [W-1:0] er, input logic [W-1:0] er2, input bit disturb);
    int da, nd, bc;
    run(m, disturb, 520, da, nd, bc);
    check({tag, "_done_at"}, W'(da), W'(513));
    check({tag, "_ndone"}, W'(nd), W'(1));
    check({tag, "_busy_cyc"}, W'(bc), W'(513));
    check({tag, "_err"}, W'(err), W'(0));
    check({tag, "_mp"}, W'(mp), W'(emp));
    check({tag, "_r_mod"}, r_mod, er);
    check({tag, "_r2_mod"}, r2_mod, er2);
    $display("txn %s m=%h mp=%h r_mod=%h r2_mod=%h", tag, m, mp, r_mod, r2_mod);
  endtask

  initial begin
    logic [W-1:0] one, m, p255;
    int da, nd, bc;
    one = '0; one[0] = 1'b1;
    p255 = one << 255;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_err", W'(err), W'(0));
    check("rst_outs", W'(mp) | r_mod | r2_mod, W'(0));
    rstn = 1'b1;

    full_check("m_2p255p1", p255 + 1, 32'hFFFFFFFF, p255 - 1, W'(4), 1'b0);
    full_check("m_2p255p3", p255 + 3, 32'h55555555, p255 - 3, W'(36), 1'b0);
    full_check("m_2p256m1", {W{1'b1}}, 32'h00000001, W'(1), W'(1), 1'b0);
    full_check("m_one", W'(1), 32'hFFFFFFFF, W'(0), W'(0), 1'b0);

    run(W'(2), 1'b0, 5, da, nd, bc);
    check("even_done_at", W'(da), W'(1));
    check("even_err", W'(err), W'(1));
    check("even_outs", W'(mp) | r_mod | r2_mod, W'(0));
    $display("txn even m=2 done_at=%0d err=%0b", da, err);

    full_check("after_err", p255 + 1, 32'hFFFFFFFF, p255 - 1, W'(4), 1'b0);
    full_check("disturb", p255 + 3, 32'h55555555, p255 - 3, W'(36), 1'b1);

    // Asynchronous reset mid-run.
    run(p255 + 1, 1'b0, 199, da, nd, bc);
    rstn = 1'b0;
    #1;
    check("arst_busy", W'(busy), W'(0));
    check("arst_outs", W'(mp) | r_mod | r2_mod, W'(0));
    check("arst_done", W'(done), W'(0));
    $display("txn async reset busy=%0b", busy);
    @(posedge clk); #1;
    rstn = 1'b1;
    full_check("restart", p255 + 3, 32'h55555555, p255 - 3, W'(36), 1'b0);

    for (int it = 0; it < 8; it++) begin
      for (int j = 0; j < 8; j++) m[j*32 +: 32] = $urandom;
      m[0] = 1'b1;
      if (it[0]) m[W-1] = 1'b1;
      full_check($sformatf("rand%0d", it), m, ref_mp(m[31:0]),
                 pow2_mod(m, W), pow2_mod(m, 2 * W), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
